// File: rtl/starfield_compositor.sv
// Starfield compositor: brightness floor, frame-rate twinkle and RGB tint on the
// starfield output, composited behind the foreground layer with matched timing.
module starfield_compositor (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sf_on,
  input  logic [7:0] sf_star,
  input  logic       fg_on,
  input  logic [7:0] fg_r,
  input  logic [7:0] fg_g,
  input  logic [7:0] fg_b,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       hblank_o,
  output logic       vblank_o
);

  typedef enum logic [2:0] {
    A_CTRL   = 3'd0,
    A_FLOOR  = 3'd1,
    A_TINT_R = 3'd2,
    A_TINT_G = 3'd3,
    A_TINT_B = 3'd4,
    A_RATE   = 3'd5
  } reg_addr_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } timing_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Scale by t/255 without a divider: (v*t + v) >> 8 is exact at t=0 and t=0xFF.
  function automatic logic [7:0] tint_ch(input logic [7:0] v, input logic [7:0] t);
    return 8'((16'(v) * 16'(t) + 16'(v)) >> 8);
  endfunction

  logic [2:0] ctrl_q;
  logic [7:0] floor_q;
  logic [7:0] rate_q;
  rgb_t       tint_q;
  logic [7:0] cnt_q;
  logic [7:0] lfsr_q;
  logic       vblank_prev_q;

  logic       s1_vis_q;
  logic [7:0] s1_b_q;
  logic [2:0] s1_tag_q;
  logic       s1_fg_on_q;
  rgb_t       s1_fg_q;
  timing_t    s1_tm_q;

  logic       s2_vis_q;
  rgb_t       s2_star_q;
  logic       s2_fg_on_q;
  rgb_t       s2_fg_q;
  timing_t    s2_tm_q;

  rgb_t       out_q;
  timing_t    out_tm_q;

  logic       frame_edge;
  logic       rate_wr;
  logic [7:0] s1_b_d;
  logic [7:0] b2_d;
  rgb_t       star_d;
  rgb_t       out_d;

  assign frame_edge = en & vblank & ~vblank_prev_q;
  assign rate_wr    = write & (addr == A_RATE);
  assign s1_b_d     = (sf_star < floor_q) ? floor_q : sf_star;

  // NOTE: all state below uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= 3'b001;
      floor_q <= 8'h00;
      tint_q  <= '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      rate_q  <= 8'h08;
    end else if (write) begin
      case (reg_addr_e'(addr))
        A_CTRL:   ctrl_q   <= data_in[2:0];
        A_FLOOR:  floor_q  <= data_in;
        A_TINT_R: tint_q.r <= data_in;
        A_TINT_G: tint_q.g <= data_in;
        A_TINT_B: tint_q.b <= data_in;
        A_RATE:   rate_q   <= data_in;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_prev_q <= 1'b0;
      cnt_q         <= 8'h00;
      lfsr_q        <= 8'hA5;
    end else begin
      if (en) vblank_prev_q <= vblank;
      if (frame_edge && rate_q != 8'd0) begin
        if (cnt_q == rate_q - 8'd1) begin
          cnt_q  <= 8'h00;
          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      // A rate write restarts the frame count even if an edge lands in the same clk.
      if (rate_wr) cnt_q <= 8'h00;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    b2_d = s1_b_q;
    if (ctrl_q[2] && s1_tag_q == lfsr_q[2:0]) b2_d = s1_b_q >> 1;
    star_d = '{r: b2_d, g: b2_d, b: b2_d};
    if (ctrl_q[1]) begin
      star_d.r = tint_ch(b2_d, tint_q.r);
      star_d.g = tint_ch(b2_d, tint_q.g);
      star_d.b = tint_ch(b2_d, tint_q.b);
    end
    out_d = '0;
    if (!(s2_tm_q.hblank || s2_tm_q.vblank)) begin
      if (s2_fg_on_q)    out_d = s2_fg_q;
      else if (s2_vis_q) out_d = s2_star_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vis_q   <= 1'b0;
      s1_b_q     <= 8'h00;
      s1_tag_q   <= 3'b000;
      s1_fg_on_q <= 1'b0;
      s1_fg_q    <= '0;
      s1_tm_q    <= '0;
      s2_vis_q   <= 1'b0;
      s2_star_q  <= '0;
      s2_fg_on_q <= 1'b0;
      s2_fg_q    <= '0;
      s2_tm_q    <= '0;
      out_q      <= '0;
      out_tm_q   <= '0;
    end else if (en) begin
      s1_vis_q   <= sf_on & ctrl_q[0] & ~hblank & ~vblank;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= sf_star[7:5];
      s1_fg_on_q <= fg_on;
      s1_fg_q    <= '{r: fg_r, g: fg_g, b: fg_b};
      s1_tm_q    <= '{hsync: hsync, vsync: vsync, hblank: hblank, vblank: vblank};
      s2_vis_q   <= s1_vis_q;
      s2_star_q  <= star_d;
      s2_fg_on_q <= s1_fg_on_q;
      s2_fg_q    <= s1_fg_q;
      s2_tm_q    <= s1_tm_q;
      out_q      <= out_d;
      out_tm_q   <= s2_tm_q;
    end
  end

  assign r        = out_q.r;
  assign g        = out_q.g;
  assign b        = out_q.b;
  assign hsync_o  = out_tm_q.hsync;
  assign vsync_o  = out_tm_q.vsync;
  assign hblank_o = out_tm_q.hblank;
  assign vblank_o = out_tm_q.vblank;

endmodule
